// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: two producer FIFOs (EX, SLB) drained round-robin onto
// a single registered result broadcast to the ROB and reservation stations.
module cdb_arbiter #(
   parameter int unsigned NICK_W = 5,
   parameter int unsigned DATA_W = 32,
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DEPTH  = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rdy,
   input  logic              iclr,
   input  logic              iEX_en,
   input  logic [NICK_W-1:0] iEX_nick,
   input  logic [DATA_W-1:0] iEX_dt,
   input  logic              iEX_ac,
   input  logic [ADDR_W-1:0] iEX_j_pc,
   output logic              oEX_full,
   input  logic              iSLB_en,
   input  logic [NICK_W-1:0] iSLB_nick,
   input  logic [DATA_W-1:0] iSLB_dt,
   output logic              oSLB_full,
   output logic              oCDB_en,
   output logic              oCDB_src,
   output logic [NICK_W-1:0] oCDB_nick,
   output logic [DATA_W-1:0] oCDB_dt,
   output logic              oCDB_ac,
   output logic [ADDR_W-1:0] oCDB_j_pc,
   output logic              oOVF
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   typedef struct packed {
      logic [NICK_W-1:0] nick;
      logic [DATA_W-1:0] dt;
      logic              ac;
      logic [ADDR_W-1:0] j_pc;
   } cdb_entry_t;

   typedef enum logic {
      SRC_EX  = 1'b0,
      SRC_SLB = 1'b1
   } src_e;

   cdb_entry_t ex_mem_q  [DEPTH];
   cdb_entry_t slb_mem_q [DEPTH];

   logic [PTR_W-1:0] ex_wr_ptr_q, ex_wr_ptr_d, ex_rd_ptr_q, ex_rd_ptr_d;
   logic [PTR_W-1:0] slb_wr_ptr_q, slb_wr_ptr_d, slb_rd_ptr_q, slb_rd_ptr_d;
   logic [CNT_W-1:0] ex_cnt_q, ex_cnt_d, slb_cnt_q, slb_cnt_d;
   src_e             last_q, last_d;
   logic             ovf_q, ovf_d;
   logic             cdb_en_q, cdb_en_d;
   src_e             cdb_src_q, cdb_src_d;
   cdb_entry_t       cdb_ent_q, cdb_ent_d;

   cdb_entry_t ex_wr_ent, slb_wr_ent;
   logic       ex_empty, slb_empty;
   logic       grant_ex, grant_slb;
   logic       ex_push, ex_pop, ex_drop;
   logic       slb_push, slb_pop, slb_drop;

   // Incoming tuples; SLB results carry no branch information.
   always_comb begin
      ex_wr_ent.nick  = iEX_nick;
      ex_wr_ent.dt    = iEX_dt;
      ex_wr_ent.ac    = iEX_ac;
      ex_wr_ent.j_pc  = iEX_j_pc;
      slb_wr_ent.nick = iSLB_nick;
      slb_wr_ent.dt   = iSLB_dt;
      slb_wr_ent.ac   = 1'b0;
      slb_wr_ent.j_pc = '0;
   end

   assign ex_empty  = (ex_cnt_q == '0);
   assign slb_empty = (slb_cnt_q == '0);

   // Round-robin: when both queues hold work, the source not granted last wins.
   assign grant_ex  = !ex_empty && (slb_empty || (last_q == SRC_SLB));
   assign grant_slb = !slb_empty && !grant_ex;

   // Early full leaves one slot for the producer's one-cycle reaction latency.
   assign oEX_full  = (ex_cnt_q >= CNT_W'(DEPTH - 1));
   assign oSLB_full = (slb_cnt_q >= CNT_W'(DEPTH - 1));

   always_comb begin
      ex_wr_ptr_d  = ex_wr_ptr_q;
      ex_rd_ptr_d  = ex_rd_ptr_q;
      ex_cnt_d     = ex_cnt_q;
      slb_wr_ptr_d = slb_wr_ptr_q;
      slb_rd_ptr_d = slb_rd_ptr_q;
      slb_cnt_d    = slb_cnt_q;
      last_d       = last_q;
      ovf_d        = ovf_q;
      cdb_en_d     = cdb_en_q;
      cdb_src_d    = cdb_src_q;
      cdb_ent_d    = cdb_ent_q;
      ex_push      = 1'b0;
      ex_pop       = 1'b0;
      ex_drop      = 1'b0;
      slb_push     = 1'b0;
      slb_pop      = 1'b0;
      slb_drop     = 1'b0;

      if (rdy) begin
         if (iclr) begin
            // Flush everything in flight except the sticky overflow flag.
            ex_wr_ptr_d  = '0;
            ex_rd_ptr_d  = '0;
            ex_cnt_d     = '0;
            slb_wr_ptr_d = '0;
            slb_rd_ptr_d = '0;
            slb_cnt_d    = '0;
            last_d       = SRC_SLB;
            cdb_en_d     = 1'b0;
            cdb_src_d    = SRC_EX;
            cdb_ent_d    = '0;
         end else begin
            ex_push  = iEX_en && (ex_cnt_q < CNT_W'(DEPTH));
            ex_drop  = iEX_en && (ex_cnt_q == CNT_W'(DEPTH));
            slb_push = iSLB_en && (slb_cnt_q < CNT_W'(DEPTH));
            slb_drop = iSLB_en && (slb_cnt_q == CNT_W'(DEPTH));
            ex_pop   = grant_ex;
            slb_pop  = grant_slb;

            if (grant_ex) begin
               cdb_en_d  = 1'b1;
               cdb_src_d = SRC_EX;
               cdb_ent_d = ex_mem_q[ex_rd_ptr_q];
               last_d    = SRC_EX;
            end else if (grant_slb) begin
               cdb_en_d  = 1'b1;
               cdb_src_d = SRC_SLB;
               cdb_ent_d = slb_mem_q[slb_rd_ptr_q];
               last_d    = SRC_SLB;
            end else begin
               cdb_en_d  = 1'b0;
            end

            if (ex_push)  ex_wr_ptr_d  = ex_wr_ptr_q + PTR_W'(1);
            if (ex_pop)   ex_rd_ptr_d  = ex_rd_ptr_q + PTR_W'(1);
            if (slb_push) slb_wr_ptr_d = slb_wr_ptr_q + PTR_W'(1);
            if (slb_pop)  slb_rd_ptr_d = slb_rd_ptr_q + PTR_W'(1);

            ex_cnt_d  = ex_cnt_q + CNT_W'(ex_push) - CNT_W'(ex_pop);
            slb_cnt_d = slb_cnt_q + CNT_W'(slb_push) - CNT_W'(slb_pop);
            ovf_d     = ovf_q | ex_drop | slb_drop;
         end
      end
   end

   // Entry storage needs no reset; validity is tracked by the pointers and counts.
   always_ff @(posedge clk) begin
      if (!rst && ex_push)  ex_mem_q[ex_wr_ptr_q]   <= ex_wr_ent;
      if (!rst && slb_push) slb_mem_q[slb_wr_ptr_q] <= slb_wr_ent;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ex_wr_ptr_q  <= '0;
         ex_rd_ptr_q  <= '0;
         ex_cnt_q     <= '0;
         slb_wr_ptr_q <= '0;
         slb_rd_ptr_q <= '0;
         slb_cnt_q    <= '0;
         last_q       <= SRC_SLB;
         ovf_q        <= 1'b0;
         cdb_en_q     <= 1'b0;
         cdb_src_q    <= SRC_EX;
         cdb_ent_q    <= '0;
      end else begin
         ex_wr_ptr_q  <= ex_wr_ptr_d;
         ex_rd_ptr_q  <= ex_rd_ptr_d;
         ex_cnt_q     <= ex_cnt_d;
         slb_wr_ptr_q <= slb_wr_ptr_d;
         slb_rd_ptr_q <= slb_rd_ptr_d;
         slb_cnt_q    <= slb_cnt_d;
         last_q       <= last_d;
         ovf_q        <= ovf_d;
         cdb_en_q     <= cdb_en_d;
         cdb_src_q    <= cdb_src_d;
         cdb_ent_q    <= cdb_ent_d;
      end
   end

   assign oCDB_en   = cdb_en_q;
   assign oCDB_src  = (cdb_src_q == SRC_SLB);
   assign oCDB_nick = cdb_ent_q.nick;
   assign oCDB_dt   = cdb_ent_q.dt;
   assign oCDB_ac   = cdb_ent_q.ac;
   assign oCDB_j_pc = cdb_ent_q.j_pc;
   assign oOVF      = ovf_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: directed scenarios then random traffic, every cycle
// compared against a queue-based model of the producer FIFOs and round-robin grant.
module tb_cdb_arbiter;
   localparam int unsigned NICK_W = 5;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned ADDR_W = 32;
   localparam int unsigned DEPTH  = 4;

   logic              clk = 1'b0;
   logic              rst, rdy, iclr;
   logic              iEX_en, iEX_ac, oEX_full;
   logic [NICK_W-1:0] iEX_nick;
   logic [DATA_W-1:0] iEX_dt;
   logic [ADDR_W-1:0] iEX_j_pc;
   logic              iSLB_en, oSLB_full;
   logic [NICK_W-1:0] iSLB_nick;
   logic [DATA_W-1:0] iSLB_dt;
   logic              oCDB_en, oCDB_src, oCDB_ac, oOVF;
   logic [NICK_W-1:0] oCDB_nick;
   logic [DATA_W-1:0] oCDB_dt;
   logic [ADDR_W-1:0] oCDB_j_pc;

   always #5 clk = ~clk;

   cdb_arbiter #(.NICK_W(NICK_W), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .rdy(rdy), .iclr(iclr),
      .iEX_en(iEX_en), .iEX_nick(iEX_nick), .iEX_dt(iEX_dt), .iEX_ac(iEX_ac),
      .iEX_j_pc(iEX_j_pc), .oEX_full(oEX_full),
      .iSLB_en(iSLB_en), .iSLB_nick(iSLB_nick), .iSLB_dt(iSLB_dt), .oSLB_full(oSLB_full),
      .oCDB_en(oCDB_en), .oCDB_src(oCDB_src), .oCDB_nick(oCDB_nick), .oCDB_dt(oCDB_dt),
      .oCDB_ac(oCDB_ac), .oCDB_j_pc(oCDB_j_pc), .oOVF(oOVF)
   );

   typedef struct {
      logic [NICK_W-1:0] nick;
      logic [DATA_W-1:0] dt;
      logic              ac;
      logic [ADDR_W-1:0] jpc;
   } ent_t;

   ent_t exq[$];
   ent_t slbq[$];
   logic m_last_slb;
   logic exp_en, exp_src, exp_ac, exp_ovf;
   logic [NICK_W-1:0] exp_nick;
   logic [DATA_W-1:0] exp_dt;
   logic [ADDR_W-1:0] exp_jpc;

   int vectors = 0;
   int miscompares = 0;
   logic [NICK_W-1:0] bc_log[$];
   logic saw_slb_full;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] expv);
      vectors++;
      assert (got === expv) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, got, expv);
      end
   endtask

   // Reference: queues per producer, grant from pre-push occupancy, drop on full.
   task automatic model(input logic rs, input logic rd, input logic cl,
                        input logic xe, input ent_t xent, input logic se, input ent_t sent);
      int nx, ns, g;
      ent_t e;
      if (rs || (rd && cl)) begin
         exq.delete();
         slbq.delete();
         exp_en = 0; exp_src = 0; exp_nick = '0; exp_dt = '0; exp_ac = 0; exp_jpc = '0;
         if (rs) exp_ovf = 0;
         m_last_slb = 1'b1;
         return;
      end
      if (!rd) return;
      nx = exq.size();
      ns = slbq.size();
      g = -1;
      if (nx > 0 && ns > 0) g = m_last_slb ? 0 : 1;
      else if (nx > 0) g = 0;
      else if (ns > 0) g = 1;
      if (g >= 0) begin
         e = (g == 0) ? exq.pop_front() : slbq.pop_front();
         exp_en = 1; exp_src = (g == 1); exp_nick = e.nick; exp_dt = e.dt;
         exp_ac = e.ac; exp_jpc = e.jpc;
         m_last_slb = (g == 1);
      end else begin
         exp_en = 0;
      end
      if (xe) begin
         if (nx < DEPTH) exq.push_back(xent); else exp_ovf = 1;
      end
      if (se) begin
         e = sent; e.ac = 0; e.jpc = '0;
         if (ns < DEPTH) slbq.push_back(e); else exp_ovf = 1;
      end
   endtask

   task automatic check_all();
      chk("cdb_en", 64'(oCDB_en), 64'(exp_en));
      chk("cdb_src", 64'(oCDB_src), 64'(exp_src));
      chk("cdb_nick", 64'(oCDB_nick), 64'(exp_nick));
      chk("cdb_dt", 64'(oCDB_dt), 64'(exp_dt));
      chk("cdb_ac", 64'(oCDB_ac), 64'(exp_ac));
      chk("cdb_j_pc", 64'(oCDB_j_pc), 64'(exp_jpc));
      chk("ex_full", 64'(oEX_full), 64'(exq.size() >= DEPTH - 1));
      chk("slb_full", 64'(oSLB_full), 64'(slbq.size() >= DEPTH - 1));
      chk("ovf", 64'(oOVF), 64'(exp_ovf));
      if (oSLB_full) saw_slb_full = 1'b1;
   endtask

   // One clock: drive inputs, advance the model, check half a cycle after the edge.
   task automatic cyc(input logic rs, input logic rd, input logic cl,
                      input logic xe, input logic [NICK_W-1:0] xn, input logic [DATA_W-1:0] xd,
                      input logic xa, input logic [ADDR_W-1:0] xj,
                      input logic se, input logic [NICK_W-1:0] sn, input logic [DATA_W-1:0] sd);
      ent_t xent, sent;
      rst = rs; rdy = rd; iclr = cl;
      iEX_en = xe; iEX_nick = xn; iEX_dt = xd; iEX_ac = xa; iEX_j_pc = xj;
      iSLB_en = se; iSLB_nick = sn; iSLB_dt = sd;
      xent.nick = xn; xent.dt = xd; xent.ac = xa; xent.jpc = xj;
      sent.nick = sn; sent.dt = sd; sent.ac = 0; sent.jpc = '0;
      model(rs, rd, cl, xe, xent, se, sent);
      @(posedge clk);
      @(negedge clk);
      check_all();
      if (rd && !rs && oCDB_en) bc_log.push_back(oCDB_nick);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(0, 1, 0, 0, '0, '0, 0, '0, 0, '0, '0);
   endtask

   initial begin
      int cnt;
      logic [NICK_W-1:0] t3_exp[6];
      t3_exp = '{5'd1, 5'd4, 5'd2, 5'd5, 5'd3, 5'd6};
      saw_slb_full = 1'b0;

      // Reset then idle
      cyc(1, 1, 0, 0, '0, '0, 0, '0, 0, '0, '0);
      idle(5);

      // Single EX push: visible one cycle later as a one-cycle pulse
      cyc(0, 1, 0, 1, 5'd3, 32'h0000_00AA, 1, 32'h0000_1004, 0, '0, '0);
      chk("t2_no_bypass", 64'(oCDB_en), 64'd0);
      idle(1);
      chk("t2_en", 64'(oCDB_en), 64'd1);
      chk("t2_src", 64'(oCDB_src), 64'd0);
      chk("t2_nick", 64'(oCDB_nick), 64'd3);
      chk("t2_dt", 64'(oCDB_dt), 64'hAA);
      chk("t2_ac", 64'(oCDB_ac), 64'd1);
      chk("t2_jpc", 64'(oCDB_j_pc), 64'h1004);
      idle(1);
      chk("t2_pulse_end", 64'(oCDB_en), 64'd0);

      // Contention from reset: EX wins first, then strict alternation
      cyc(1, 1, 0, 0, '0, '0, 0, '0, 0, '0, '0);
      bc_log.delete();
      for (int i = 0; i < 3; i++)
         cyc(0, 1, 0, 1, NICK_W'(i + 1), 32'(100 + i), 0, 32'(i), 1, NICK_W'(i + 4), 32'(200 + i));
      idle(6);
      chk("t3_count", 64'(bc_log.size()), 64'd6);
      for (int i = 0; i < 6; i++)
         if (i < bc_log.size()) chk($sformatf("t3_seq%0d", i), 64'(bc_log[i]), 64'(t3_exp[i]));
      idle(2);
      chk("t3_idle", 64'(oCDB_en), 64'd0);

      // Backpressure and overflow: both producers push every cycle
      for (int i = 0; i < 8; i++)
         cyc(0, 1, 0, 1, NICK_W'(10 + i), 32'($urandom), 1, 32'($urandom), 1, NICK_W'(20 + i), 32'($urandom));
      chk("t4_slb_full_seen", 64'(saw_slb_full), 64'd1);
      chk("t4_ovf", 64'(oOVF), 64'd1);
      idle(20);
      chk("t4_ovf_sticky", 64'(oOVF), 64'd1);

      // Flush with concurrent SLB push
      for (int i = 0; i < 3; i++) cyc(0, 1, 0, 1, NICK_W'(1 + i), 32'(i), 0, '0, 0, '0, '0);
      bc_log.delete();
      cyc(0, 1, 1, 0, '0, '0, 0, '0, 1, 5'd7, 32'h77);
      chk("t5_en", 64'(oCDB_en), 64'd0);
      chk("t5_ovf_kept", 64'(oOVF), 64'd1);
      idle(5);
      cnt = 0;
      foreach (bc_log[i]) if (bc_log[i] == 5'd7) cnt++;
      chk("t5_nick7_count", 64'(cnt), 64'd0);
      chk("t5_bus_count", 64'(bc_log.size()), 64'd0);

      // rdy stall: entry waits, then is broadcast exactly once
      bc_log.delete();
      cyc(0, 1, 0, 1, 5'd9, 32'h99, 0, 32'h900, 0, '0, '0);
      for (int i = 0; i < 4; i++) cyc(0, 0, 0, 1, 5'd11, 32'h1, 0, '0, 1, 5'd12, 32'h2);
      chk("t6_stalled", 64'(oCDB_en), 64'd0);
      idle(3);
      cnt = 0;
      foreach (bc_log[i]) if (bc_log[i] == 5'd9) cnt++;
      chk("t6_nick9_once", 64'(cnt), 64'd1);
      chk("t6_bus_count", 64'(bc_log.size()), 64'd1);

      // Random traffic
      cyc(1, 1, 0, 0, '0, '0, 0, '0, 0, '0, '0);
      for (int i = 0; i < 400; i++) begin
         cyc(($urandom_range(0, 199) == 0), ($urandom_range(0, 9) != 0), ($urandom_range(0, 39) == 0),
             1'($urandom), NICK_W'($urandom_range(1, 31)), 32'($urandom), 1'($urandom), 32'($urandom),
             1'($urandom), NICK_W'($urandom_range(1, 31)), 32'($urandom));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
